// File: rtl/riscv_seq_divider.sv
// Iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU with stall and result strobe.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module riscv_seq_divider #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1,
   parameter int TAG_W  = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start_valid,
   output logic             o_start_ready,
   input  logic [2:0]       i_funct3,
   input  logic [XLEN-1:0]  i_a,
   input  logic [XLEN-1:0]  i_b,
   input  logic [TAG_W-1:0] i_tag_in,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_stall,
   output logic             o_result_valid,
   output logic [XLEN-1:0]  o_result,
   output logic [TAG_W-1:0] o_tag_out
);

   localparam int N     = XLEN / UNROLL;
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [TAG_W-1:0] r_tag;
   logic             r_is_rem;
   logic             r_sign_a;
   logic             r_sign_b;
   logic [XLEN-1:0]  r_dvd;
   logic [XLEN-1:0]  r_dvs;
   logic [XLEN:0]    r_rem;
   logic [XLEN-1:0]  r_result;
   logic [TAG_W-1:0] r_tag_out;

   logic            w_accept;
   logic            w_signed;
   logic            w_illegal;
   logic            w_div0;
   logic            w_ovf;
   logic            w_special;
   logic            w_sign_a;
   logic            w_sign_b;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic [XLEN-1:0] w_special_res;
   logic            w_hit;
   logic [XLEN-1:0] w_hit_res;
   logic            w_quick;
   logic [XLEN-1:0] w_quick_res;
   logic [XLEN:0]   w_rem_nx;
   logic [XLEN-1:0] w_dvd_nx;
   logic [XLEN-1:0] w_quot;
   logic [XLEN-1:0] w_remf;
   logic [XLEN-1:0] w_final;
   logic            w_last;

   assign o_start_ready  = (r_state == S_IDLE) && !i_flush && !i_reset;
   assign o_busy         = (r_state != S_IDLE);
   assign o_stall        = !i_reset &&
                           ((i_start_valid && (r_state == S_IDLE)) || (r_state == S_ITER));
   assign o_result_valid = (r_state == S_DONE) && !i_flush;
   assign o_result       = r_result;
   assign o_tag_out      = r_tag_out;

   assign w_accept  = i_start_valid && o_start_ready;
   assign w_signed  = !i_funct3[0];
   assign w_illegal = !i_funct3[2];
   assign w_div0    = (i_b == '0);
   assign w_ovf     = w_signed && (i_b == '1) && (i_a == {1'b1, {(XLEN-1){1'b0}}});
   assign w_special = w_illegal || w_div0 || w_ovf;
   assign w_sign_a  = w_signed && i_a[XLEN-1];
   assign w_sign_b  = w_signed && i_b[XLEN-1];
   assign w_mag_a   = w_sign_a ? -i_a : i_a;
   assign w_mag_b   = w_sign_b ? -i_b : i_b;

   // ISA-defined results that need no iteration
   always_comb begin
      w_special_res = '0;
      if (w_illegal)   w_special_res = '0;
      else if (w_div0) w_special_res = i_funct3[1] ? i_a : '1;
      else if (w_ovf)  w_special_res = i_funct3[1] ? '0 : i_a;
   end

   always_comb begin
      w_rem_nx = r_rem;
      w_dvd_nx = r_dvd;
      for (int i = 0; i < UNROLL; i++) begin
         w_rem_nx = {w_rem_nx[XLEN-1:0], w_dvd_nx[XLEN-1]};
         w_dvd_nx = {w_dvd_nx[XLEN-2:0], 1'b0};
         if (w_rem_nx >= {1'b0, r_dvs}) begin
            w_rem_nx    = w_rem_nx - {1'b0, r_dvs};
            w_dvd_nx[0] = 1'b1;
         end
      end
   end

   assign w_quot  = (r_sign_a ^ r_sign_b) ? -w_dvd_nx : w_dvd_nx;
   assign w_remf  = r_sign_a ? -w_rem_nx[XLEN-1:0] : w_rem_nx[XLEN-1:0];
   assign w_final = r_is_rem ? w_remf : w_quot;
   assign w_last  = (r_state == S_ITER) && (r_cnt == CNT_LAST);

`ifdef DIV_RESULT_CACHE_EN
   logic            r_c_valid;
   logic [XLEN-1:0] r_c_a;
   logic [XLEN-1:0] r_c_b;
   logic            r_c_uns;
   logic [XLEN-1:0] r_c_quot;
   logic [XLEN-1:0] r_c_rem;
   logic [XLEN-1:0] r_raw_a;
   logic [XLEN-1:0] r_raw_b;
   logic            r_uns;

   assign w_hit     = r_c_valid && !w_special && (i_a == r_c_a) && (i_b == r_c_b) &&
                      (i_funct3[0] == r_c_uns);
   assign w_hit_res = i_funct3[1] ? r_c_rem : r_c_quot;

   // Only reset invalidates; flushed ops never reach the store
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_c_valid <= 1'b0;
         r_c_a     <= '0;
         r_c_b     <= '0;
         r_c_uns   <= 1'b0;
         r_c_quot  <= '0;
         r_c_rem   <= '0;
         r_raw_a   <= '0;
         r_raw_b   <= '0;
         r_uns     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_raw_a <= i_a;
            r_raw_b <= i_b;
            r_uns   <= i_funct3[0];
         end
         if (w_last && !i_flush) begin
            r_c_valid <= 1'b1;
            r_c_a     <= r_raw_a;
            r_c_b     <= r_raw_b;
            r_c_uns   <= r_uns;
            r_c_quot  <= w_quot;
            r_c_rem   <= w_remf;
         end
      end
   end
`else
   assign w_hit     = 1'b0;
   assign w_hit_res = '0;
`endif

   assign w_quick     = w_special || w_hit;
   assign w_quick_res = w_special ? w_special_res : w_hit_res;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_tag     <= '0;
         r_is_rem  <= 1'b0;
         r_sign_a  <= 1'b0;
         r_sign_b  <= 1'b0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_rem     <= '0;
         r_result  <= '0;
         r_tag_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tag    <= i_tag_in;
                  r_is_rem <= i_funct3[1];
                  r_sign_a <= w_sign_a;
                  r_sign_b <= w_sign_b;
                  r_dvd    <= w_mag_a;
                  r_dvs    <= w_mag_b;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  if (w_quick) begin
                     r_state   <= S_DONE;
                     r_result  <= w_quick_res;
                     r_tag_out <= i_tag_in;
                  end else begin
                     r_state <= S_ITER;
                  end
               end
            end
            S_ITER: begin
               if (i_flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_rem_nx;
                  r_dvd <= w_dvd_nx;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_state   <= S_DONE;
                     r_result  <= w_final;
                     r_tag_out <= r_tag;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Directed scoreboard bench for riscv_seq_divider (32-bit default instance plus a 64-bit, 4x unrolled one).
module tb_riscv_seq_divider;

   localparam int LAT_FULL = 33;
`ifdef DIV_RESULT_CACHE_EN
   localparam int LAT_HIT = 1;
`else
   localparam int LAT_HIT = 33;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sv, sr, flush, busy, stall, rv;
   logic [2:0]  f3;
   logic [31:0] a, b, res;
   logic [4:0]  tag, tago;

   logic        sv64, sr64, busy64, stall64, rv64;
   logic [2:0]  f3_64;
   logic [63:0] a64, b64, res64;
   logic [4:0]  tag64, tago64;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int n_rv    = 0;

   logic [31:0] q_res[$];
   logic [4:0]  q_tag[$];
   logic [63:0] q64[$];

   riscv_seq_divider u_dut (
      .i_clk(clk), .i_reset(rst), .i_start_valid(sv), .o_start_ready(sr),
      .i_funct3(f3), .i_a(a), .i_b(b), .i_tag_in(tag), .i_flush(flush),
      .o_busy(busy), .o_stall(stall), .o_result_valid(rv), .o_result(res), .o_tag_out(tago)
   );

   riscv_seq_divider #(.XLEN(64), .UNROLL(4), .TAG_W(5)) u_dut64 (
      .i_clk(clk), .i_reset(rst), .i_start_valid(sv64), .o_start_ready(sr64),
      .i_funct3(f3_64), .i_a(a64), .i_b(b64), .i_tag_in(tag64), .i_flush(1'b0),
      .o_busy(busy64), .o_stall(stall64), .o_result_valid(rv64), .o_result(res64),
      .o_tag_out(tago64)
   );

   always @(negedge clk) if (rv === 1'b1) n_rv++;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Called at posedge+1 with the divider idle; returns at posedge+1 of the cycle after DONE.
   task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [4:0] t, input logic [31:0] exp,
                        input int exp_lat, input bit hold);
      int lat;
      q_res.push_back(exp);
      q_tag.push_back(t);
      f3 = f; a = aa; b = bb; tag = t; sv = 1'b1;
      @(negedge clk);
      check({name, "_ready"}, sr, 1);
      check({name, "_stall0"}, stall, 1);
      @(posedge clk); #1;
      if (!hold) begin
         sv = 1'b0; a = $urandom; b = $urandom; f3 = 3'($urandom); tag = 5'($urandom);
      end
      lat = 1;
      @(negedge clk);
      while (!rv && lat < 200) begin
         check({name, "_stall_iter"}, stall, 1);
         lat++;
         @(negedge clk);
      end
      check({name, "_lat"}, lat, exp_lat);
      if (rv) begin
         check({name, "_stall_done"}, stall, 0);
         check({name, "_ready_done"}, sr, 0);
         check({name, "_res"}, res, q_res.pop_front());
         check({name, "_tag"}, tago, q_tag.pop_front());
      end else begin
         void'(q_res.pop_front());
         void'(q_tag.pop_front());
      end
      @(posedge clk); #1;
      sv = 1'b0;
      @(negedge clk);
      check({name, "_idle"}, busy, 0);
      check({name, "_rv_once"}, rv, 0);
      check({name, "_res_hold"}, res, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      int lat64;
      int rv_before;
      rst = 1'b1; sv = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0; tag = '0;
      sv64 = 1'b0; f3_64 = '0; a64 = '0; b64 = '0; tag64 = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", sr, 0);
      check("rst_busy", busy, 0);
      check("rst_stall", stall, 0);
      check("rst_rv", rv, 0);
      check("rst_res", res, 0);
      check("rst_tag", tago, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, LAT_FULL, 1'b0);
      do_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, LAT_HIT, 1'b0);
      do_op("divu",     3'b101, 32'd100, 32'd7, 5'd3, 32'd14, LAT_FULL, 1'b1);
      do_op("remu",     3'b111, 32'd100, 32'd7, 5'd4, 32'd2, LAT_HIT, 1'b0);
      do_op("divu_z",   3'b101, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1, 1'b0);
      do_op("rem_z",    3'b110, 32'd5, 32'd0, 5'd6, 32'd5, 1, 1'b0);
      do_op("rem_zn",   3'b110, 32'hFFFF_FFF9, 32'd0, 5'd7, 32'hFFFF_FFF9, 1, 1'b0);
      do_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, 1'b0);
      do_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1, 1'b0);
      do_op("illegal",  3'b010, 32'd17, 32'd3, 5'd10, 32'd0, 1, 1'b0);
      do_op("div_mix",  3'b100, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, LAT_FULL, 1'b0);
      do_op("rem_mix",  3'b110, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, LAT_HIT, 1'b0);
      do_op("remu_big", 3'b111, 32'hFFFF_FFFF, 32'd10, 5'd13, 32'd5, LAT_FULL, 1'b0);
      do_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'd10, 5'd14, 32'h1999_9999, LAT_HIT, 1'b0);

      // Flush in cycle 10 of DIVU 1000/3, with a new request held against the flush
      f3 = 3'b101; a = 32'd1000; b = 32'd3; tag = 5'd15; sv = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0;
      @(negedge clk);
      check("flush_accepted", busy, 1);
      rv_before = n_rv;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1; sv = 1'b1; f3 = 3'b101; a = 32'd9; b = 32'd3; tag = 5'd16;
      @(negedge clk);
      check("flush_ready", sr, 0);
      check("flush_rv", rv, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      do_op("after_flush", 3'b101, 32'd9, 32'd3, 5'd16, 32'd3, LAT_FULL, 1'b0);
      check("flush_rv_count", n_rv - rv_before, 1);

      // Asynchronous reset in cycle 15 of an op
      f3 = 3'b100; a = 32'd1000; b = 32'd7; tag = 5'd20; sv = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0;
      rv_before = n_rv;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_stall", stall, 0);
      check("arst_rv", rv, 0);
      check("arst_res", res, 0);
      check("arst_tag", tago, 0);
      check("arst_ready", sr, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op("div_after_rst", 3'b100, 32'd20, 32'hFFFF_FFFC, 5'd21, 32'hFFFF_FFFB, LAT_FULL, 1'b0);
      check("arst_rv_count", n_rv - rv_before, 1);

      do_op("c_div",  3'b100, 32'd1234, 32'd10, 5'd22, 32'd123, LAT_FULL, 1'b0);
      do_op("c_rem",  3'b110, 32'd1234, 32'd10, 5'd23, 32'd4, LAT_HIT, 1'b0);
      do_op("c_divu", 3'b101, 32'd1234, 32'd10, 5'd24, 32'd123, LAT_FULL, 1'b0);

      // 64-bit, four quotient bits per cycle: DIVU 2^40 / 3
      q64.push_back(64'h0000_0055_5555_5555);
      f3_64 = 3'b101; a64 = 64'h0000_0100_0000_0000; b64 = 64'd3; tag64 = 5'd5; sv64 = 1'b1;
      @(negedge clk);
      check("d64_ready", sr64, 1);
      @(posedge clk); #1;
      sv64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      lat64 = 1;
      @(negedge clk);
      while (!rv64 && lat64 < 200) begin
         lat64++;
         @(negedge clk);
      end
      check("d64_lat", lat64, 17);
      if (rv64) begin
         check("d64_res", res64, q64.pop_front());
         check("d64_tag", tago64, 5);
      end
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/riscv_seq_divider.md
Name: riscv_seq_divider

Overview:
- Parametrised, self-contained iterative divider for the EX stage; no vendor divider IP.
- Implements RV32M/RV64M DIV, DIVU, REM and REMU, including the ISA-defined results for divide-by-zero and signed overflow.
- Uses a valid/ready start handshake and a one-cycle result strobe.
- Drives a pipeline stall. The stall drops in the completion cycle, so the same EX instruction is never re-issued as a new division.

Parameters:
- XLEN, 32, operand and result width; 32 or 64.
- UNROLL, 1, quotient bits resolved per cycle; 1, 2 or 4; must divide XLEN.
- TAG_W, 5, width of the destination-register tag carried with the operation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_valid  in  1  EX holds a divide op with operands valid
- start_ready  out  1  divider can accept an op
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  dividend (rs1)
- b  in  XLEN  divisor (rs2)
- tag_in  in  TAG_W  rd index
- flush  in  1  kill any in-flight op (branch/trap)
- busy  out  1  op in flight (state ITER or DONE)
- stall  out  1  hold the pipeline front end
- result_valid  out  1  one-cycle strobe, result valid
- result  out  XLEN  quotient or remainder, per the latched funct3
- tag_out  out  TAG_W  tag of the completed op

Behaviour:
- Reset: state IDLE. busy, stall, result_valid, result and tag_out are 0. start_ready is forced 0 while reset is high.
- States and transitions:
  - IDLE -> ITER on accept of a normal op.
  - IDLE -> DONE on accept of a special case (b==0, overflow, illegal funct3).
  - ITER -> DONE after N = XLEN/UNROLL iteration cycles.
  - DONE -> IDLE unconditionally.
- start_ready = (state==IDLE) && !flush. Accept = start_valid && start_ready.
- On accept, latch funct3, tag_in, sign flags and magnitudes:
  - |a|, |b| for DIV/REM.
  - Raw a, b for DIVU/REMU.
- stall = (start_valid && state==IDLE) || state==ITER. stall is 0 in DONE and 0 when idle with no request.
- Latency: accept in cycle 0. Normal ops spend cycles 1..N in ITER. DONE with result_valid=1 is cycle N+1 (33 for XLEN=32, UNROLL=1). Special cases reach DONE in cycle 1.
- Core: unsigned restoring division on an XLEN+1-bit partial remainder, shifting in UNROLL dividend bits per cycle.
- Sign fix, applied registered on entry to DONE:
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder takes the sign of the dividend.
- b==0: quotient = all ones; remainder = a (unmodified, original sign).
- Signed overflow (DIV/REM, a = most-negative, b = all ones): quotient = a, remainder = 0.
- Illegal funct3 (0xx): result 0, 1-cycle path, result_valid still pulses.
- result and tag_out hold their value after DONE until the next completion. result_valid is high only in DONE.
- No re-accept in DONE, even with start_valid still high, because start_ready=0 there.
- flush (synchronous, any state):
  - Next state is IDLE; result_valid is suppressed.
  - result and tag_out are unchanged.
  - flush coincident with start_valid does not accept.
- Async reset mid-operation aborts immediately. No result_valid is produced for the aborted op.
- Operands a, b and funct3 need only be valid in the accept cycle.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- When defined:
  - On every normal completion, store the final quotient and remainder plus the raw a, b and the signedness (funct3[0]).
  - A later accept with identical a, b and signedness goes directly to DONE in cycle 1. It returns the quotient or remainder selected by the new funct3.
  - The cache is invalidated by reset only; flush does not invalidate it.
  - Special cases bypass the cache.
- When undefined: no cache storage, and every normal op takes N+1 cycles.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD (-3), result_valid in cycle 33. REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU a=100, b=7 -> 14; REMU -> 2. Check stall is high in cycles 0..32 and low in cycle 33. Check no second accept while start_valid stays high through DONE.
- b=0: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Then DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Each gives result_valid in cycle 1.
- Accept DIVU 1000/3, assert flush in cycle 10 -> no result_valid, start_ready=1 in cycle 11. A new DIVU 9/3 accepted in cycle 11 -> 3 with result_valid in cycle 44.
- Reset asserted in cycle 15 of an op -> all outputs 0 immediately. After release, a fresh DIV 20/-4 -> 0xFFFFFFFB.
- DIV_RESULT_CACHE_EN: DIV 1234/10 (done in cycle 33, result 123), then REM 1234/10 -> 4 in cycle 1. DIVU with the same bits -> full latency. Also run with XLEN=64 and UNROLL=4: DIVU 2^40/3 -> 0x5555555555, result_valid in cycle 17.
